// File: rtl/flatten_buffer_if.sv
// Stream-in / parallel-out bundle between the max-pool stream, flatten_buffer and the FC layer.
// The buffer uses the slave modport; the producer/FC side (or a bench) uses master.
interface flatten_buffer_if #(
  parameter int DEPTH  = 225,
  parameter int DATA_W = 22
);
  logic                     i_valid;
  logic signed [DATA_W-1:0] i_data;
  logic                     i_last;
  logic                     o_ready;
  logic signed [DATA_W-1:0] o_flattened_data [0:DEPTH-1];
  logic                     o_fc_start;
  logic                     i_fc_done;
  logic                     o_busy;
  logic                     o_frame_err;

  modport slave (
    input  i_valid, i_data, i_last, i_fc_done,
    output o_ready, o_flattened_data, o_fc_start, o_busy, o_frame_err
  );

  modport master (
    output i_valid, i_data, i_last, i_fc_done,
    input  o_ready, o_flattened_data, o_fc_start, o_busy, o_frame_err
  );
endinterface

// File: rtl/flatten_buffer.sv
// Collects one raster-ordered feature map into a register array, starts the FC layer and holds
// the array frozen until the FC result arrives. Optional macro FLATTEN_RELU_EN clamps negatives to 0.
module flatten_buffer #(
  parameter int DEPTH  = 225,
  parameter int DATA_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  flatten_buffer_if.slave   bus
);

  localparam int                 CNT_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
  logic signed [DATA_W-1:0] buf_q [0:DEPTH-1];
  logic                     done_d1_q;
  logic                     fc_start_q, fc_start_d;
  logic                     busy_q, busy_d;
  logic                     frame_err_q, frame_err_d;
  logic                     ready_s;
  logic                     accept_s;
  logic                     at_end_s;
  logic                     done_rise_s;
  logic                     wr_en_s;

  function automatic logic signed [DATA_W-1:0] store_val(input logic signed [DATA_W-1:0] d);
`ifdef FLATTEN_RELU_EN
    if (d[DATA_W-1]) begin
      store_val = {DATA_W{1'b0}};
    end else begin
      store_val = d;
    end
`else
    store_val = d;
`endif
  endfunction

  assign ready_s     = (state_q == S_IDLE) || (state_q == S_FILL);
  assign accept_s    = bus.i_valid && ready_s;
  assign at_end_s    = (wr_cnt_q == LAST_IDX);
  assign done_rise_s = bus.i_fc_done && !done_d1_q;

  // Next-state, write enable and registered-output next values.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    wr_en_s     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept_s) begin
          if (bus.i_last && !at_end_s) begin
            // Short frame: drop this beat and restart; earlier entries get overwritten later.
            wr_cnt_d    = {CNT_W{1'b0}};
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
          end else if (at_end_s) begin
            wr_en_s     = 1'b1;
            wr_cnt_d    = {CNT_W{1'b0}};
            state_d     = S_START;
            frame_err_d = !bus.i_last;
          end else begin
            wr_en_s     = 1'b1;
            wr_cnt_d    = wr_cnt_q + CNT_W'(1);
            state_d     = S_FILL;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d  = S_IDLE;
        wr_cnt_d = {CNT_W{1'b0}};
      end
    endcase
    fc_start_d = (state_d == S_START);
    busy_d     = (state_d == S_START) || (state_d == S_WAIT);
  end

  // Control state, counter, done edge detector and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= {CNT_W{1'b0}};
      done_d1_q   <= 1'b0;
      fc_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      done_d1_q   <= bus.i_fc_done;
      fc_start_q  <= fc_start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Element storage; only written while filling, so it is frozen through START and WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        buf_q[k] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      buf_q[wr_cnt_q] <= store_val(bus.i_data);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign bus.o_flattened_data[g] = buf_q[g];
  end

  assign bus.o_ready     = ready_s;
  assign bus.o_fc_start  = fc_start_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_flatten_buffer.sv
// Directed bench for flatten_buffer: full frames, backpressure, release, framing errors, reset, ReLU.
module tb_flatten_buffer;
  localparam int DEPTH  = 225;
  localparam int DATA_W = 22;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   fc_cnt = 0;
  int   err_cnt = 0;
  int   fc0;
  int   er0;
  logic [DATA_W-1:0] exp7;

  always #5 clk = ~clk;

  flatten_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  flatten_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.o_fc_start === 1'b1) fc_cnt++;
    if (bus.o_frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Number of entries that differ from the expected frame (zero frame, or k+base with optional entry 7 override).
  function automatic int mism(input int base, input bit zero, input bit neg7);
    int n;
    logic [DATA_W-1:0] e;
    n = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (zero) e = '0;
      else if (neg7 && k == 7) e = exp7;
      else e = DATA_W'(k + base);
      if (bus.o_flattened_data[k] !== e) n++;
    end
    return n;
  endfunction

  task automatic beat(input logic [DATA_W-1:0] d, input logic l);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_last  = l;
    @(posedge clk);
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(posedge clk);
  endtask

  initial begin
`ifdef FLATTEN_RELU_EN
    exp7 = 22'h000000;
`else
    exp7 = 22'h3FFFFB;
`endif
    bus.i_valid   = 1'b0;
    bus.i_data    = '0;
    bus.i_last    = 1'b0;
    bus.i_fc_done = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_start", 32'(bus.o_fc_start), 32'd0);
    check("rst_err", 32'(bus.o_frame_err), 32'd0);
    check("rst_buf", 32'(mism(0, 1'b1, 1'b0)), 32'd0);

    // Gap-free frame, element k = k+1
    #1 fc0 = fc_cnt; er0 = err_cnt;
    for (int k = 0; k < DEPTH; k++) beat(DATA_W'(k + 1), k == DEPTH - 1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    check("a_start_pulse", 32'(bus.o_fc_start), 32'd1);
    check("a_busy1", 32'(bus.o_busy), 32'd1);
    check("a_ready1", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    check("a_start_end", 32'(bus.o_fc_start), 32'd0);
    check("a_busy2", 32'(bus.o_busy), 32'd1);
    #1;
    check("a_start_cnt", 32'(fc_cnt - fc0), 32'd1);
    check("a_err_cnt", 32'(err_cnt - er0), 32'd0);
    check("a_buf", 32'(mism(1, 1'b0, 1'b0)), 32'd0);

    // Backpressure in WAIT
    repeat (20) begin
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_data  = 22'h03FFFF;
    end
    @(negedge clk);
    check("bp_ready", 32'(bus.o_ready), 32'd0);
    check("bp_busy", 32'(bus.o_busy), 32'd1);
    check("bp_buf", 32'(mism(1, 1'b0, 1'b0)), 32'd0);
    bus.i_valid   = 1'b0;
    bus.i_fc_done = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(bus.o_ready), 32'd1);
    check("rel_busy", 32'(bus.o_busy), 32'd0);
    repeat (16) @(negedge clk);
    check("rel_hold_busy", 32'(bus.o_busy), 32'd0);
    check("rel_hold_ready", 32'(bus.o_ready), 32'd1);
    #1;
    check("rel_start_cnt", 32'(fc_cnt - fc0), 32'd1);
    bus.i_fc_done = 1'b0;

    // Early i_last on index 100
    @(negedge clk);
    #1 fc0 = fc_cnt; er0 = err_cnt;
    for (int k = 0; k <= 100; k++) beat(DATA_W'(k + 1001), k == 100);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    check("el_err_pulse", 32'(bus.o_frame_err), 32'd1);
    check("el_ready", 32'(bus.o_ready), 32'd1);
    check("el_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    check("el_err_end", 32'(bus.o_frame_err), 32'd0);
    #1;
    check("el_err_cnt", 32'(err_cnt - er0), 32'd1);
    check("el_start_cnt", 32'(fc_cnt - fc0), 32'd0);
    check("el_e0", {10'd0, bus.o_flattened_data[0]}, 32'd1001);
    check("el_e99", {10'd0, bus.o_flattened_data[99]}, 32'd1100);
    check("el_e100", {10'd0, bus.o_flattened_data[100]}, 32'd101);

    // Gapped frame; i_fc_done already high so only a fresh rise releases
    bus.i_fc_done = 1'b1;
    fc0 = fc_cnt; er0 = err_cnt;
    for (int k = 0; k < DEPTH; k++) begin
      if ($urandom_range(0, 1) == 1) idle_cyc();
      beat(DATA_W'(k + 1), k == DEPTH - 1);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    check("g_start_pulse", 32'(bus.o_fc_start), 32'd1);
    check("g_busy", 32'(bus.o_busy), 32'd1);
    repeat (6) @(negedge clk);
    check("g_held_busy", 32'(bus.o_busy), 32'd1);
    check("g_held_ready", 32'(bus.o_ready), 32'd0);
    #1;
    check("g_start_cnt", 32'(fc_cnt - fc0), 32'd1);
    check("g_err_cnt", 32'(err_cnt - er0), 32'd0);
    check("g_buf", 32'(mism(1, 1'b0, 1'b0)), 32'd0);
    @(negedge clk);
    bus.i_fc_done = 1'b0;
    @(negedge clk);
    check("g_prerise_busy", 32'(bus.o_busy), 32'd1);
    bus.i_fc_done = 1'b1;
    @(negedge clk);
    check("g_rel_busy", 32'(bus.o_busy), 32'd0);
    check("g_rel_ready", 32'(bus.o_ready), 32'd1);
    bus.i_fc_done = 1'b0;

    // Reset after 50 accepts
    @(negedge clk);
    #1 fc0 = fc_cnt;
    for (int k = 0; k < 50; k++) beat(DATA_W'(k + 2001), 1'b0);
    #2;
    rst = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check("mr_buf", 32'(mism(0, 1'b1, 1'b0)), 32'd0);
    check("mr_ready", 32'(bus.o_ready), 32'd1);
    check("mr_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("mr_start_cnt", 32'(fc_cnt - fc0), 32'd0);

    // Fresh frame, element 7 = -5, final element without i_last
    fc0 = fc_cnt; er0 = err_cnt;
    for (int k = 0; k < DEPTH; k++) beat((k == 7) ? 22'h3FFFFB : DATA_W'(k + 1), 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("ml_start_pulse", 32'(bus.o_fc_start), 32'd1);
    check("ml_err_pulse", 32'(bus.o_frame_err), 32'd1);
    check("ml_busy", 32'(bus.o_busy), 32'd1);
    @(negedge clk);
    #1;
    check("ml_start_cnt", 32'(fc_cnt - fc0), 32'd1);
    check("ml_err_cnt", 32'(err_cnt - er0), 32'd1);
    check("ml_e7", {10'd0, bus.o_flattened_data[7]}, {10'd0, exp7});
    check("ml_buf", 32'(mism(1, 1'b0, 1'b1)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flatten_buffer.md
# flatten_buffer

Collects one 15×15 feature map, streamed in raster order from the pooling stage, into a 225-entry register array and presents it in parallel to the fully connected layer. After the last element arrives it issues a one-cycle start pulse, then freezes the array and refuses input until the FC layer reports its result. It sits between the max-pool output stream and `i_flattened_data`/`i_start` of the FC layer.

## Interface
- `DEPTH`, 225, number of elements per frame; index range 0..DEPTH-1.
- `DATA_W`, 22, signed element width.

- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  input element valid.
- `i_data`  in  DATA_W signed  input element.
- `i_last`  in  1  marks the final element of a frame; sampled only on an accepted beat.
- `o_ready`  out  1  element accepted when `i_valid & o_ready`.
- `o_flattened_data`  out  DATA_W signed ×[0:DEPTH-1]  buffered frame; entry k = k-th accepted element.
- `o_fc_start`  out  1  one-cycle start pulse to the FC layer.
- `i_fc_done`  in  1  FC result-valid level; its rising edge releases the buffer.
- `o_busy`  out  1  high in START and WAIT.
- `o_frame_err`  out  1  one-cycle pulse on a framing error.

## Operation
- States: IDLE, FILL, START, WAIT.
- `o_ready` is combinational: 1 in IDLE and FILL, 0 in START and WAIT.
- `wr_cnt` runs 0..DEPTH-1. On each accepted beat, `buf[wr_cnt] <= i_data` and `wr_cnt` increments.
- IDLE: the first accepted beat writes index 0 and moves to FILL.
- FILL, normal completion: the beat accepted with `wr_cnt == DEPTH-1` is written, `wr_cnt` clears to 0, and the state moves to START.
- Early `i_last`: an accepted beat with `i_last=1` and `wr_cnt != DEPTH-1` is discarded. `wr_cnt` clears to 0, the state returns to IDLE and `o_frame_err` pulses. Entries already written are left in place; the next frame overwrites them.
- Missing `i_last`: if the element at index DEPTH-1 arrives with `i_last=0`, the frame still completes normally and `o_frame_err` pulses.
- START: `o_fc_start=1` for exactly one cycle, then WAIT.
- WAIT:
  - The buffer is frozen and `i_valid` is ignored.
  - `done_d1` registers `i_fc_done` every cycle in every state. A rising edge is `i_fc_done & ~done_d1`.
  - A rising edge seen in WAIT returns the state to IDLE on the next clock.
  - Rising edges seen in IDLE, FILL or START are ignored.
  - A level of `i_fc_done` held over from the previous frame produces no edge and does not release the buffer.
- The buffer contents must not change from the START cycle until WAIT is left. The FC layer reads entries across its ~230-cycle compute window.
- No arithmetic; data passes through unchanged, apart from the optional ReLU below.

## Timing
- Reset values:
  - State IDLE, `wr_cnt` 0, every buffer entry 0.
  - `o_fc_start` 0, `o_frame_err` 0, `o_busy` 0, `o_ready` 1 (combinational from IDLE), `done_d1` 0.
- Write latency: a beat accepted at edge N is visible on `o_flattened_data` after edge N.
- Completion: if the final beat is accepted at edge N, `o_fc_start` is high during cycle N+1 only, and `o_busy` is high from cycle N+1.
- Release: if `i_fc_done` rises before edge M, the state is IDLE after edge M, with `o_ready=1` and `o_busy=0`.
- Minimum frame period is DEPTH+2 cycles plus the FC latency. Gaps in `i_valid` are allowed anywhere.
- Reset asserted mid-frame: all state clears immediately, asynchronously, and the partial frame is lost.

## Configuration
- `FLATTEN_RELU_EN` defined: on write, negative `i_data` is stored as 0 and non-negative values are stored unchanged. Framing behaviour is identical.
- Undefined: `i_data` is stored unchanged, including negatives.

## Test plan
- Full frame, element k = k+1, `i_last` on k=224, with no gaps:
  - `o_flattened_data[k] = k+1` for every k.
  - `o_fc_start` pulses once, in the cycle after the 225th accept.
  - `o_busy=1` and `o_ready=0` until `i_fc_done` rises.
- Backpressure and release:
  - Drive `i_valid=1` with data 0x3FFFF throughout WAIT: the buffer is unchanged.
  - Raise `i_fc_done` for 17 cycles: IDLE one cycle after the rise, with only one release.
- Random `i_valid` gaps (~50% duty) over a full frame: the result is identical to the gap-free case, with exactly one `o_fc_start`.
- Early `i_last` on index 100:
  - `o_frame_err` pulses once, state returns to IDLE, `o_fc_start` stays 0.
  - A following full frame completes correctly.
- Reset asserted after 50 accepts: all entries read 0, `o_ready=1`, no `o_fc_start`. A fresh frame then completes correctly.
- Element 7 = -5 (22'h3FFFFB): reads 0 with `FLATTEN_RELU_EN` defined, and -5 without it.
